mux_n_sel: RTL
==============

Name: mux_n_sel

Overview:
- Parametrised, registered N-way channel selector for datapath steering in the CPU.
- Generalises the fixed 9-input combinational mux to configurable width and channel count.
- Adds per-channel valid/ready handshakes, a one-entry output register and two selection modes:
  - explicit flag select;
  - round-robin arbitration.
- Sits between multiple producers (ALU, memory, immediate and PC paths) and a single consumer stage.

Parameters:
- WIDTH, 32, data width of each channel.
- N, 9, number of input channels (2..16).
- SEL_W, 4, width of flag and out_chan; must satisfy 2**SEL_W >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational.
- flag  input  SEL_W  channel select, used in mode 0.
- mode  input  1  0 = flag select, 1 = round-robin.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- err  output  1  registered one-cycle pulse: flag out of range in mode 0.

Behaviour:
- Reset (async, rst_n low) clears all state immediately:
  - out_data = 0, out_valid = 0, out_chan = 0, err = 0, rr_ptr = 0.
  - in_ready = 0 while reset is asserted.
- Release is synchronous to clk: the first load can occur on the first rising edge with rst_n high.
- Output register states:
  - EMPTY (out_valid = 0), FULL (out_valid = 1).
  - load_en = !out_valid || out_ready, so the register can be refilled in the same cycle it drains (full throughput).
- Selection, computed combinationally each cycle:
  - Mode 0: sel = flag; sel_ok = (flag < N) && in_valid[flag].
  - Mode 1: sel = first i with in_valid[i] set, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N; sel_ok = |in_valid.
- Handshake:
  - in_ready[i] = load_en && sel_ok && (i == sel).
  - At most one in_ready bit is high in any cycle.
- Transfer on a clock edge with in_valid[sel] && in_ready[sel]:
  - out_data <= channel sel data; out_chan <= sel; out_valid <= 1.
  - Latency is exactly 1 cycle from accept to out_valid.
- Rotation:
  - On a mode 1 transfer, rr_ptr <= (sel == N-1) ? 0 : sel + 1.
  - Mode 0 transfers do not change rr_ptr.
- No transfer while load_en is high:
  - out_valid <= 0 if out_ready drained the register; otherwise the register holds.
  - out_data and out_chan are held, not cleared.
- Held word while FULL and out_ready = 0:
  - out_data and out_chan are stable.
  - Changes on flag, mode or in_data have no effect on the held word.
- err:
  - Set for one cycle when mode = 0, flag >= N and load_en = 1; no transfer occurs.
  - Otherwise err <= 0.
- Mode switches take effect on the next selection; rr_ptr is retained across mode changes.
- With no in_valid bits set, no transfer occurs and no error is raised.
- Reset asserted mid-transfer discards the held word; out_valid drops asynchronously.

Optional Feature:
- Macro MUX_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit), the even parity (XOR reduction) of the word loaded into out_data.
  - out_parity is registered and loaded together with out_data; reset value 0.
  - Held with out_data when the register is not loaded.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset + mode 0:
  - Stimulus: N=9, flag=3, in_valid=9'h008, ch3=32'hDEADBEEF, out_ready=1.
  - Response: in_ready=9'h008; next cycle out_data=32'hDEADBEEF, out_chan=3, out_valid=1.
- Out of range:
  - Stimulus: mode 0, flag=4'd12, in_valid=9'h1FF.
  - Response: in_ready=0, err=1 for one cycle, out_valid unchanged.
- Round-robin fairness:
  - Stimulus: mode 1, in_valid=9'h1FF held, out_ready=1.
  - Response: out_chan sequence 0,1,...,8,0; out_valid continuously 1 from the second cycle.
- Back-pressure:
  - Stimulus: out_ready=0 after the first load of ch2=32'h00000055; toggle flag and in_data for 5 cycles.
  - Response: out_data stays 32'h00000055, out_chan=2, in_ready=0; on out_ready=1 the new word loads the same cycle.
- Sparse round-robin wrap:
  - Stimulus: mode 1, rr_ptr=7, in_valid=9'h012.
  - Response: grants ch1, then ch4, then ch1.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clock edges while out_valid=1.
  - Response: out_valid=0, out_data=0 and rr_ptr=0 immediately, before the next edge.
  - With MUX_PARITY_EN: out_parity=0 after reset; ch0=32'h00000007 loads out_parity=1.

Source files
------------

// File: rtl/mux_n_sel.sv
// rtl/mux_n_sel.sv - registered N-way channel selector, flag or round-robin (optional MUX_PARITY_EN adds out_parity)
module mux_n_sel #(
  parameter int WIDTH = 32,
  parameter int N     = 9,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   flag,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_chan,
  output logic               err
`ifdef MUX_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  localparam int PAD = 2**SEL_W;
  localparam logic [SEL_W:0]   N_L  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_err;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [PAD-1:0]   w_valid_pad;
  logic             w_flag_in_range;
  logic [SEL_W-1:0] w_rr_sel;
  logic             w_rr_found;
  logic [SEL_W:0]   w_idx;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_ok;
  logic             w_load_en;
  logic             w_xfer;
  logic             w_err_next;
  logic [WIDTH-1:0] w_sel_data;

  // Padding in_valid to a power of two lets flag index it safely even when out of range.
  assign w_valid_pad     = PAD'(in_valid);
  assign w_flag_in_range = ({1'b0, flag} < N_L);

  // Round-robin scan from rr_ptr with wrap; descending loop so the nearest requester wins.
  always_comb begin
    w_rr_sel   = '0;
    w_rr_found = 1'b0;
    w_idx      = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (w_idx >= N_L) begin
        w_idx = w_idx - N_L;
      end
      if (w_valid_pad[w_idx[SEL_W-1:0]]) begin
        w_rr_sel   = w_idx[SEL_W-1:0];
        w_rr_found = 1'b1;
      end
    end
  end

  assign w_sel      = mode ? w_rr_sel : flag;
  assign w_sel_ok   = mode ? w_rr_found : (w_flag_in_range && w_valid_pad[flag]);
  // Gating with rst_n keeps every in_ready low while reset is held.
  assign w_load_en  = rst_n && (!r_out_valid || out_ready);
  assign w_xfer     = w_load_en && w_sel_ok;
  assign w_err_next = w_load_en && !mode && !w_flag_in_range;
  assign in_ready   = w_xfer ? (N'(1) << w_sel) : '0;

  // Data mux over the real channels only, avoiding out-of-range slices.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == SEL_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register, error pulse and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_err       <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_err <= w_err_next;
      if (w_xfer) begin
        r_out_data  <= w_sel_data;
        r_out_chan  <= w_sel;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_rr_ptr <= (w_sel == LAST) ? '0 : w_sel + SEL_W'(1);
        end
      end else if (w_load_en) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_PARITY_EN
  logic r_parity;

  // Parity travels with the data word and is held alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= ^w_sel_data;
    end
  end

  assign out_parity = r_parity;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign err       = r_err;

endmodule
